// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite blitter.
package sprite_pkg;

   localparam int DEF_SPR_W = 36;
   localparam int DEF_SPR_H = 28;
   localparam int DEF_COL_W = 3;
   localparam int DEF_SCR_W = 320;
   localparam int DEF_SCR_H = 240;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   // Bits needed to hold an index 0..n-1 (never less than one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_blit_if.sv
// Request, ROM and plot signals of the sprite blitter bundled as one port.
interface sprite_blit_if
   import sprite_pkg::*;
#(
   parameter int X_W    = 9,
   parameter int Y_W    = 8,
   parameter int COL_W  = DEF_COL_W,
   parameter int ADDR_W = $clog2(DEF_SPR_W * DEF_SPR_H)
) ();

   logic              start;
   logic [X_W-1:0]    x_;
   logic [Y_W-1:0]    y_;
   logic              flip_h;
   logic [ADDR_W-1:0] rom_addr;
   logic [COL_W-1:0]  rom_q;
   logic [X_W-1:0]    out_x;
   logic [Y_W-1:0]    out_y;
   logic [COL_W-1:0]  out_colour;
   logic              out_valid;
   logic              busy;
   logic              done;

   // Blitter side.
   modport slave (
      input  start, x_, y_, flip_h, rom_q,
      output rom_addr, out_x, out_y, out_colour, out_valid, busy, done
   );

   // Requester / ROM / framebuffer side.
   modport master (
      output start, x_, y_, flip_h, rom_q,
      input  rom_addr, out_x, out_y, out_colour, out_valid, busy, done
   );

endinterface

// File: rtl/sprite_scan_counter.sv
// Raster scan over the sprite: column, row and a row base address stepped
// by SPR_W so the ROM address needs only an adder.
module sprite_scan_counter
   import sprite_pkg::*;
#(
   parameter int SPR_W  = DEF_SPR_W,
   parameter int SPR_H  = DEF_SPR_H,
   parameter int ADDR_W = $clog2(SPR_W * SPR_H),
   parameter int CW     = idx_w(SPR_W),
   parameter int RW     = idx_w(SPR_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              step_i,
   output logic [CW-1:0]     col_o,
   output logic [RW-1:0]     row_o,
   output logic [ADDR_W-1:0] row_base_o,
   output logic              last_o
);

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              col_end, row_end;

   assign col_end = (col_q == CW'(SPR_W - 1));
   assign row_end = (row_q == RW'(SPR_H - 1));

   // Next position: advance column, wrap into the next row, wrap fully after the last pixel.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      col_d  = col_q;
      row_d  = row_q;
      base_d = base_q;
      if (clear_i) begin
         col_d  = '0;
         row_d  = '0;
         base_d = '0;
      end else if (step_i) begin
         if (col_end) begin
            col_d = '0;
            if (row_end) begin
               row_d  = '0;
               base_d = '0;
            end else begin
               row_d  = row_q + 1'b1;
               base_d = base_q + ADDR_W'(SPR_W);
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Position registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         base_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         base_q <= base_d;
      end
   end

   assign col_o      = col_q;
   assign row_o      = row_q;
   assign row_base_o = base_q;
   assign last_o     = col_end && row_end;

endmodule

// File: rtl/sprite_blit.sv
// Sprite blitter: scans a sprite ROM, optionally mirrored, and emits clipped,
// colour-keyed plot strobes one cycle behind each ROM address.
module sprite_blit
   import sprite_pkg::*;
#(
   parameter int SPR_W = DEF_SPR_W,
   parameter int SPR_H = DEF_SPR_H,
   parameter int COL_W = DEF_COL_W,
   parameter int X_W   = 9,
   parameter int Y_W   = 8,
   parameter int SCR_W = DEF_SCR_W,
   parameter int SCR_H = DEF_SCR_H,
   parameter int KEY   = 0
) (
   input  logic          clock_all,
   input  logic          reset_all,
   sprite_blit_if.slave  bus
);

   localparam int ADDR_W = $clog2(SPR_W * SPR_H);
   localparam int CW     = idx_w(SPR_W);
   localparam int RW     = idx_w(SPR_H);

   localparam logic [X_W:0]     SCR_W_L = (X_W + 1)'(SCR_W);
   localparam logic [Y_W:0]     SCR_H_L = (Y_W + 1)'(SCR_H);
   localparam logic [COL_W-1:0] KEY_L   = COL_W'(KEY);

   state_e            state_q, state_d;
   logic [X_W-1:0]    x0_q, x0_d;
   logic [Y_W-1:0]    y0_q, y0_d;
   logic              flip_q, flip_d;
   logic              accept, running;

   logic [CW-1:0]     col, col_s_q, col_eff;
   logic [RW-1:0]     row, row_s_q;
   logic [ADDR_W-1:0] row_base;
   logic              last;
   logic              vld_s_q;

   logic [X_W:0]      sum_x;
   logic [Y_W:0]      sum_y;
   logic              clip;

   sprite_scan_counter #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .ADDR_W (ADDR_W),
      .CW     (CW),
      .RW     (RW)
   ) u_scan (
      .clk        (clock_all),
      .rst        (reset_all),
      .clear_i    (accept),
      .step_i     (running),
      .col_o      (col),
      .row_o      (row),
      .row_base_o (row_base),
      .last_o     (last)
   );

   // Sequencer: accept a request only when idle, then scan, drain the pipe and pulse done.
   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      flip_d  = flip_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               x0_d    = bus.x_;
               y0_d    = bus.y_;
               flip_d  = bus.flip_h;
               state_d = S_RUN;
            end
         end
         S_RUN:   if (last) state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched request registers.
   always_ff @(posedge clock_all) begin
      if (reset_all) begin
         state_q <= S_IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         flip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         flip_q  <= flip_d;
      end
   end

   // Pipeline stage lining the scan position up with the ROM read data.
   always_ff @(posedge clock_all) begin
      if (reset_all) begin
         vld_s_q <= 1'b0;
         col_s_q <= '0;
         row_s_q <= '0;
      end else begin
         vld_s_q <= running;
         col_s_q <= col;
         row_s_q <= row;
      end
   end

   assign running = (state_q == S_RUN);

   // Mirroring only changes which column of the current row is fetched.
   assign col_eff      = flip_q ? (CW'(SPR_W - 1) - col) : col;
   assign bus.rom_addr = running ? (row_base + ADDR_W'(col_eff)) : '0;

   // One spare bit so a sum that runs past the port width still reads as off-screen.
   assign sum_x = {1'b0, x0_q} + (X_W + 1)'(col_s_q);
   assign sum_y = {1'b0, y0_q} + (Y_W + 1)'(row_s_q);
   assign clip  = (sum_x >= SCR_W_L) || (sum_y >= SCR_H_L);

   assign bus.out_x      = sum_x[X_W-1:0];
   assign bus.out_y      = sum_y[Y_W-1:0];
   assign bus.out_colour = bus.rom_q;
   assign bus.out_valid  = vld_s_q && !clip && (bus.rom_q != KEY_L);
   assign bus.busy       = running || (state_q == S_DRAIN);
   assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_blit.sv
// Scoreboard bench for sprite_blit: a raster reference model fills a queue of
// expected plots (with their cycle) and a negedge monitor pops and compares.
module tb_sprite_blit;
   import sprite_pkg::*;

   localparam int W   = DEF_SPR_W;
   localparam int H   = DEF_SPR_H;
   localparam int N   = W * H;
   localparam int AW  = $clog2(N);
   localparam int W2  = 8;
   localparam int H2  = 4;
   localparam int N2  = W2 * H2;
   localparam int AW2 = $clog2(N2);

   typedef struct {
      int c;
      int x;
      int y;
      int col;
   } pix_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   done2_cnt = 0;
   int   plot_cnt = 0;
   int   exp_done = -1;
   int   exp_done2 = -1;
   pix_t q[$];
   pix_t q2[$];
   logic [2:0] rom  [N];
   logic [8:0] rom2 [N2];

   sprite_blit_if #(.X_W(9), .Y_W(8), .COL_W(3), .ADDR_W(AW))  bus  ();
   sprite_blit_if #(.X_W(9), .Y_W(8), .COL_W(9), .ADDR_W(AW2)) bus2 ();

   sprite_blit dut (
      .clock_all (clk),
      .reset_all (rst),
      .bus       (bus)
   );

   sprite_blit #(.SPR_W(W2), .SPR_H(H2), .COL_W(9)) dut_small (
      .clock_all (clk),
      .reset_all (rst),
      .bus       (bus2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROMs, one cycle read latency.
   always @(posedge clk) begin
      bus.rom_q  <= rom[bus.rom_addr];
      bus2.rom_q <= rom2[bus2.rom_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for the default-size blitter.
   always @(negedge clk) begin : mon
      pix_t e;
      if (bus.out_valid === 1'b1) begin
         plot_cnt++;
         if (q.size() == 0) begin
            check("unexpected_pixel", 1, 0);
         end else begin
            e = q.pop_front();
            check("pix_cycle", cyc, e.c);
            check("pix_x", bus.out_x, e.x);
            check("pix_y", bus.out_y, e.y);
            check("pix_colour", bus.out_colour, e.col);
         end
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         check("done_cycle", cyc, exp_done);
      end
   end

   // Monitor for the 8x4 blitter.
   always @(negedge clk) begin : mon2
      pix_t e;
      if (bus2.out_valid === 1'b1) begin
         if (q2.size() == 0) begin
            check("small_unexpected_pixel", 1, 0);
         end else begin
            e = q2.pop_front();
            check("small_pix_cycle", cyc, e.c);
            check("small_pix_x", bus2.out_x, e.x);
            check("small_pix_y", bus2.out_y, e.y);
            check("small_pix_colour", bus2.out_colour, e.col);
         end
      end
      if (bus2.done === 1'b1) begin
         done2_cnt++;
         check("small_done_cycle", cyc, exp_done2);
      end
   end

   // Reference: walk the sprite in raster order; pixel k appears 2 cycles after start + k.
   task automatic expect_draw(input int x0, input int y0, input bit flip, input int c0);
      pix_t p;
      for (int r = 0; r < H; r++) begin
         for (int k = 0; k < W; k++) begin
            int src;
            src   = r * W + (flip ? (W - 1 - k) : k);
            p.c   = c0 + r * W + k + 2;
            p.x   = x0 + k;
            p.y   = y0 + r;
            p.col = int'(rom[src]);
            if (p.x < DEF_SCR_W && p.y < DEF_SCR_H && p.col != 0) q.push_back(p);
         end
      end
      exp_done = c0 + N + 2;
   endtask

   task automatic launch(input int x0, input int y0, input bit flip, output int c0);
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.x_     = 9'(x0);
      bus.y_     = 8'(y0);
      bus.flip_h = flip;
      c0 = cyc;
      expect_draw(x0, y0, flip, c0);
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.x_     = 9'($urandom);
      bus.y_     = 8'($urandom);
      bus.flip_h = 1'($urandom);
   endtask

   task automatic goto_cycle(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_done(input string name);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 2000 && done_cnt == d0; i++) @(posedge clk);
      check({name, "_done_seen"}, done_cnt - d0, 1);
      @(negedge clk);
      check({name, "_busy_after"}, bus.busy, 0);
      check({name, "_queue_empty"}, q.size(), 0);
   endtask

   task automatic fill_rand(input int lo);
      for (int i = 0; i < N; i++) rom[i] = 3'($urandom_range(7, lo));
   endtask

   task automatic run_small();
      pix_t p;
      int c0, d0;
      for (int i = 0; i < N2; i++) rom2[i] = 9'(i + 100);
      d0 = done2_cnt;
      @(posedge clk); #1;
      bus2.start  = 1'b1;
      bus2.x_     = 9'd5;
      bus2.y_     = 8'd7;
      bus2.flip_h = 1'b0;
      c0 = cyc;
      for (int k = 0; k < N2; k++) begin
         p.c   = c0 + k + 2;
         p.x   = 5 + k % W2;
         p.y   = 7 + k / W2;
         p.col = k + 100;
         q2.push_back(p);
      end
      exp_done2 = c0 + N2 + 2;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      for (int off = 1; off <= N2 + 3; off++) begin
         @(negedge clk);
         check("small_addr", bus2.rom_addr, (off <= N2) ? off - 1 : 0);
      end
      repeat (3) @(posedge clk);
      check("small_done_count", done2_cnt - d0, 1);
      check("small_queue_empty", q2.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, d0;
      bus.start = 1'b0;  bus.x_ = '0;  bus.y_ = '0;  bus.flip_h = 1'b0;
      bus2.start = 1'b0; bus2.x_ = '0; bus2.y_ = '0; bus2.flip_h = 1'b0;
      for (int i = 0; i < N; i++) rom[i] = 3'(i % 7);
      for (int i = 0; i < N2; i++) rom2[i] = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_rom_addr", bus.rom_addr, 0);
      check("rst_out_x", bus.out_x, 0);
      check("rst_out_y", bus.out_y, 0);

      // ROM = address mod 7, origin (10,20): colour-0 pixels suppressed.
      plot_cnt = 0;
      launch(10, 20, 1'b0, c0);
      wait_done("mod7");
      check("mod7_plot_count", plot_cnt, 864);

      // Mirrored draw.
      fill_rand(1);
      launch(50, 40, 1'b1, c0);
      wait_done("flip");

      // Clipping at the bottom-right corner: 20x10 visible pixels.
      fill_rand(1);
      plot_cnt = 0;
      launch(300, 230, 1'b0, c0);
      wait_done("clip");
      check("clip_plot_count", plot_cnt, 200);

      // Start pulses during RUN and during DONE are ignored.
      fill_rand(0);
      d0 = done_cnt;
      launch(100, 100, 1'b0, c0);
      goto_cycle(c0 + 300);
      bus.start = 1'b1; bus.x_ = '0; bus.y_ = '0;
      @(posedge clk); #1 bus.start = 1'b0;
      goto_cycle(c0 + N + 2);
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("restart_done_count", done_cnt - d0, 1);
      check("restart_busy", bus.busy, 0);
      check("restart_queue_empty", q.size(), 0);

      // Reset in the middle of a draw aborts it without a done pulse.
      fill_rand(0);
      launch(20, 30, 1'b0, c0);
      goto_cycle(c0 + 500);
      rst = 1'b1;
      @(posedge clk); #1;
      q.delete();
      exp_done = -1;
      rst = 1'b0;
      d0 = done_cnt;
      @(negedge clk);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_rom_addr", bus.rom_addr, 0);
      check("abort_out_x", bus.out_x, 0);
      check("abort_out_y", bus.out_y, 0);
      goto_cycle(c0 + N + 100);
      check("abort_no_done", done_cnt - d0, 0);
      launch(0, 0, 1'b0, c0);
      wait_done("after_abort");

      // Random origins, orientations and sprite contents.
      for (int t = 0; t < 3; t++) begin
         fill_rand(0);
         launch($urandom_range(340, 0), $urandom_range(250, 0), 1'($urandom), c0);
         wait_done("random");
      end

      // Reduced geometry: 8x4 sprite, 9-bit colour.
      run_small();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_blit.md
SPRITE_BLIT -- requirements
Module: sprite_blit

Interface
REQ-001 The block SHALL have parameter SPR_W, default 36, meaning sprite width in pixels.
REQ-002 The block SHALL have parameter SPR_H, default 28, meaning sprite height in pixels.
REQ-003 The block SHALL have parameter COL_W, default 3, meaning colour bits per pixel.
REQ-004 The block SHALL have parameters X_W, default 9, and Y_W, default 8, meaning screen coordinate widths.
REQ-005 The block SHALL have parameters SCR_W, default 320, and SCR_H, default 240, meaning visible screen size used for clipping.
REQ-006 The block SHALL have parameter KEY, default 0, meaning the transparent colour value.
REQ-007 ADDR_W SHALL be a derived localparam equal to clog2(SPR_W*SPR_H).
REQ-008 Port clock_all: input, 1 bit; the single clock, all logic on its rising edge.
REQ-009 Port reset_all: input, 1 bit; reset, synchronous, active-high.
REQ-010 Port start: input, 1 bit; requests one sprite draw.
REQ-011 Port x_: input, X_W bits; sprite origin column. Port y_: input, Y_W bits; sprite origin row.
REQ-012 Port flip_h: input, 1 bit; when high, the sprite is drawn mirrored horizontally.
REQ-013 Port rom_addr: output, ADDR_W bits; read address to the external sprite ROM, which has 1-cycle synchronous read latency.
REQ-014 Port rom_q: input, COL_W bits; ROM read data.
REQ-015 Ports out_x (X_W bits), out_y (Y_W bits) and out_colour (COL_W bits): outputs; pixel to plot.
REQ-016 Port out_valid: output, 1 bit; plot strobe. Port busy: output, 1 bit. Port done: output, 1 bit; one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-018 In IDLE, start=1 SHALL latch x_, y_ and flip_h, clear col and row, and enter RUN; start in any other state SHALL be ignored.
REQ-019 In RUN, col SHALL increment each cycle; at col=SPR_W-1 it SHALL wrap to 0 and row SHALL increment.
REQ-020 At col=SPR_W-1 and row=SPR_H-1 the FSM SHALL enter DRAIN; DRAIN SHALL last 1 cycle and go to DONE; DONE SHALL last 1 cycle and go to IDLE.
REQ-021 rom_addr SHALL be row*SPR_W+col, or row*SPR_W+(SPR_W-1-col) when latched flip=1.
REQ-022 rom_addr SHALL be formed from a row-base register stepped by SPR_W, with no multiplier.
REQ-023 rom_addr SHALL be 0 outside RUN.
REQ-024 A one-stage pipeline register SHALL hold col, row and a valid bit, so outputs align with rom_q one cycle after the address.
REQ-025 out_x SHALL equal x0+col_d and out_y SHALL equal y0+row_d, truncated to the port width; out_colour SHALL equal rom_q.
REQ-026 Sums SHALL be computed 1 bit wider than the port; a pixel SHALL be clipped when the wide sum is >= SCR_W or >= SCR_H.
REQ-027 out_valid SHALL be high iff the stage valid bit is 1, the pixel is not clipped, and rom_q != KEY.
REQ-028 busy SHALL be high in RUN and DRAIN; done SHALL be high only in DONE.
REQ-029 Latency: for start sampled at cycle 0, pixel k SHALL appear at cycle k+2, and done SHALL be high at cycle SPR_W*SPR_H+2.

Reset
REQ-030 While reset_all=1 at a clock edge, the FSM SHALL go to IDLE and col, row, the stage valid bit, the origin registers and the flip register SHALL clear to 0.
REQ-031 After reset, out_valid, busy and done SHALL be 0, rom_addr SHALL be 0, and out_x and out_y SHALL be 0.
REQ-032 Reset asserted mid-draw SHALL abort the draw with no done pulse.

Structure
REQ-033 Package sprite_pkg SHALL hold the state enum typedef and the default SPR_W, SPR_H, COL_W, SCR_W and SCR_H constants.
REQ-034 A single sub-module, sprite_scan_counter, SHALL implement col, row and the row base with wrap and last detection.

Verification
REQ-035 Default parameters, start at (10,20), flip=0, ROM holds address mod 7 -> 1008 pixels, first at (10,20) with colour 0 suppressed, done at cycle 1010, busy low after.
REQ-036 flip=1, ROM row 0 holds 0..35 -> at (x0,y0) colour is rom[35], and at x0+35 colour is rom[0].
REQ-037 Origin (300,230) -> pixels with x>=320 or y>=240 have out_valid=0; 20x10 pixels plotted.
REQ-038 start pulsed again during RUN and during DONE -> ignored, exactly one done pulse.
REQ-039 reset_all asserted at cycle 500 -> next cycle IDLE, outputs 0, no done pulse; a new start then completes normally.
REQ-040 SPR_W=8, SPR_H=4, COL_W=9 -> done at cycle 34, addresses 0..31 in order.
